// File: rtl/div_operand_fifo.sv
// Operand-pair FIFO feeding a signed divider: first-word-fall-through head,
// registered full/empty flags and a divide-by-zero hint for the head entry.
module div_operand_fifo #(
  parameter int D_BITS = 32,
  parameter int DEPTH  = 16,
  parameter int A_BITS = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic signed [D_BITS-1:0] wr_dividend,
  input  logic signed [D_BITS-1:0] wr_divisor,
  output logic                     full,
  input  logic                     rd_en,
  output logic signed [D_BITS-1:0] dividend,
  output logic signed [D_BITS-1:0] divisor,
  output logic                     div_zero,
  output logic                     empty,
  output logic        [A_BITS:0]   level
);

  localparam logic [A_BITS:0]   FULL_LEVEL = (A_BITS+1)'(DEPTH);
  localparam logic [A_BITS-1:0] PTR_ONE    = {{(A_BITS-1){1'b0}}, 1'b1};
  localparam logic [A_BITS:0]   LVL_ONE    = {{A_BITS{1'b0}}, 1'b1};

  logic signed [D_BITS-1:0] mem_dividend [DEPTH];
  logic signed [D_BITS-1:0] mem_divisor  [DEPTH];

  logic [A_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_BITS:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok, pop_ok;

  always_comb begin
    // reset gates the push so storage is never written while held in reset
    push_ok  = wr_en && !full_q && reset;
    pop_ok   = rd_en && !empty_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == FULL_LEVEL);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_dividend[wr_ptr_q] <= wr_dividend;
      mem_divisor[wr_ptr_q]  <= wr_divisor;
    end
  end

  assign dividend = empty_q ? '0 : mem_dividend[rd_ptr_q];
  assign divisor  = empty_q ? '0 : mem_divisor[rd_ptr_q];
  assign div_zero = !empty_q && (divisor == '0);
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;

endmodule

// File: tb/tb_div_operand_fifo.sv
// Directed self-checking bench for div_operand_fifo (D_BITS=32, DEPTH=16).
module tb_div_operand_fifo;

  logic               clock = 1'b0;
  logic               reset;
  logic               wr_en;
  logic signed [31:0] wr_dividend;
  logic signed [31:0] wr_divisor;
  logic               full;
  logic               rd_en;
  logic signed [31:0] dividend;
  logic signed [31:0] divisor;
  logic               div_zero;
  logic               empty;
  logic [4:0]         level;

  int total = 0;
  int bad   = 0;

  div_operand_fifo #(.D_BITS(32), .DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_dividend(wr_dividend), .wr_divisor(wr_divisor), .full(full),
    .rd_en(rd_en), .dividend(dividend), .divisor(divisor), .div_zero(div_zero),
    .empty(empty), .level(level)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, pass the rising edge, then sample 1ns later.
  task automatic cycle(input logic w, input int a, input int b, input logic r);
    wr_en = w; wr_dividend = a; wr_divisor = b; rd_en = r;
    @(posedge clock); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_dividend = 0; wr_divisor = 0;
    #12;
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    total++; if (dividend !== 32'sd0 || divisor !== 32'sd0 || div_zero !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_outputs got=%0d,%0d,%b exp=0,0,0", dividend, divisor, div_zero);
    end
    cycle(1'b1, 77, 77, 1'b0);
    total++; if (level !== 5'd0 || empty !== 1'b1) begin
      bad++; $display("[TB] FAIL push_in_reset level=%0d empty=%b exp=0,1", level, empty);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_push_pop();
    cycle(1'b1, 100, 7, 1'b0);
    total++; if (level !== 5'd1 || empty !== 1'b0) begin bad++; $display("[TB] FAIL pp_level1 got=%0d empty=%b exp=1,0", level, empty); end
    total++; if (dividend !== 32'sd100 || divisor !== 32'sd7) begin bad++; $display("[TB] FAIL pp_head1 got=%0d,%0d exp=100,7", dividend, divisor); end
    cycle(1'b1, -50, 5, 1'b0);
    total++; if (level !== 5'd2 || dividend !== 32'sd100) begin bad++; $display("[TB] FAIL pp_level2 got=%0d head=%0d exp=2,100", level, dividend); end
    cycle(1'b0, 0, 0, 1'b1);
    total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL pp_level_pop1 got=%0d exp=1", level); end
    total++; if (dividend !== -32'sd50 || divisor !== 32'sd5) begin bad++; $display("[TB] FAIL pp_head2 got=%0d,%0d exp=-50,5", dividend, divisor); end
    cycle(1'b0, 0, 0, 1'b1);
    total++; if (level !== 5'd0 || empty !== 1'b1 || dividend !== 32'sd0) begin
      bad++; $display("[TB] FAIL pp_drained level=%0d empty=%b head=%0d exp=0,1,0", level, empty, dividend);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) cycle(1'b1, i, i + 1, 1'b0);
    total++; if (full !== 1'b1 || level !== 5'd16) begin bad++; $display("[TB] FAIL fill_full full=%b level=%0d exp=1,16", full, level); end
    cycle(1'b1, 99, 99, 1'b0);
    total++; if (level !== 5'd16 || full !== 1'b1 || dividend !== 32'sd0) begin
      bad++; $display("[TB] FAIL overflow_drop level=%0d full=%b head=%0d exp=16,1,0", level, full, dividend);
    end
    for (int i = 0; i < 16; i++) begin
      total++; if (dividend !== i || divisor !== i + 1) begin
        bad++; $display("[TB] FAIL drain_order[%0d] got=%0d,%0d exp=%0d,%0d", i, dividend, divisor, i, i + 1);
      end
      cycle(1'b0, 0, 0, 1'b1);
    end
    total++; if (empty !== 1'b1 || level !== 5'd0) begin bad++; $display("[TB] FAIL drain_empty empty=%b level=%0d exp=1,0", empty, level); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) cycle(1'b1, i * 3, i, 1'b0);
    cycle(1'b1, 555, 555, 1'b1);
    total++; if (level !== 5'd15 || full !== 1'b0) begin bad++; $display("[TB] FAIL simfull_level level=%0d full=%b exp=15,0", level, full); end
    total++; if (dividend !== 32'sd3 || divisor !== 32'sd1) begin bad++; $display("[TB] FAIL simfull_head got=%0d,%0d exp=3,1", dividend, divisor); end
    for (int i = 1; i < 16; i++) cycle(1'b0, 0, 0, 1'b1);
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL simfull_drain empty=%b exp=1", empty); end
  endtask

  task automatic test_simul_empty();
    cycle(1'b1, 8, 2, 1'b1);
    total++; if (level !== 5'd1 || empty !== 1'b0) begin bad++; $display("[TB] FAIL simempty_level level=%0d empty=%b exp=1,0", level, empty); end
    total++; if (dividend !== 32'sd8 || divisor !== 32'sd2) begin bad++; $display("[TB] FAIL simempty_head got=%0d,%0d exp=8,2", dividend, divisor); end
    cycle(1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_div_zero();
    cycle(1'b1, 42, 0, 1'b0);
    total++; if (div_zero !== 1'b1 || dividend !== 32'sd42) begin bad++; $display("[TB] FAIL dz_set div_zero=%b head=%0d exp=1,42", div_zero, dividend); end
    cycle(1'b1, -9, -3, 1'b1);
    total++; if (div_zero !== 1'b0 || divisor !== -32'sd3) begin bad++; $display("[TB] FAIL dz_nonzero div_zero=%b divisor=%0d exp=0,-3", div_zero, divisor); end
    cycle(1'b0, 0, 0, 1'b1);
    total++; if (empty !== 1'b1 || div_zero !== 1'b0) begin bad++; $display("[TB] FAIL dz_clear empty=%b div_zero=%b exp=1,0", empty, div_zero); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 10 + i, 20 + i, 1'b0);
    total++; if (level !== 5'd5) begin bad++; $display("[TB] FAIL mid_level5 got=%0d exp=5", level); end
    #2 reset = 1'b0;
    #1;
    total++; if (empty !== 1'b1 || level !== 5'd0 || full !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset_flags empty=%b level=%0d full=%b exp=1,0,0", empty, level, full);
    end
    total++; if (dividend !== 32'sd0 || divisor !== 32'sd0 || div_zero !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset_out got=%0d,%0d,%b exp=0,0,0", dividend, divisor, div_zero);
    end
    @(posedge clock); #2 reset = 1'b1;
    cycle(1'b1, 3, 1, 1'b0);
    total++; if (level !== 5'd1 || dividend !== 32'sd3 || divisor !== 32'sd1) begin
      bad++; $display("[TB] FAIL mid_after_push level=%0d head=%0d,%0d exp=1,3,1", level, dividend, divisor);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_fill_overflow();
    test_simul_full();
    test_simul_empty();
    test_div_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
